// File: rtl/ber_seq_pkg.sv
// Shared encodings and widths for the BER test sequencer and its watchdog.
package ber_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ALIGN  = 3'd2;
  localparam logic [2:0] ST_ARM    = 3'd3;
  localparam logic [2:0] ST_BURST  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CLEAR  = ST_CLEAR,
    ALIGN  = ST_ALIGN,
    ARM    = ST_ARM,
    BURST  = ST_BURST,
    FINISH = ST_FINISH
  } state_e;

  // Must match the receiver's checking window length.
  localparam int BURST_LEN = 1024;
  localparam int RECV_W    = 58;
  localparam int ERR_W     = 64;
  localparam int NB_W      = 16;
  localparam int WD_W      = 16;

endpackage

// File: rtl/ber_watchdog.sv
// No-progress watchdog: counts enabled cycles, fires on the cycle the count reaches TIMEOUT_CYC.
module ber_watchdog
  import ber_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = en_i && !clr_i && (cnt_d == WD_W'(TIMEOUT_CYC));

endmodule

// File: rtl/ber_test_sequencer.sv
// Run sequencer for the PRBS receiver: clear, wait for alignment, arm NBURST windows,
// track completion via the received-word count, then snapshot results.
module ber_test_sequencer
  import ber_seq_pkg::*;
#(
  parameter int ALIGN_STABLE = 16,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NB_W-1:0]   nburst_i,
  input  logic              aligned_i,
  input  logic [RECV_W-1:0] recv_cnt_i,
  input  logic [ERR_W-1:0]  err_cnt_i,
  output logic              clr_o,
  output logic              init_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              aborted_o,
  output logic [NB_W-1:0]   burst_cnt_o,
  output logic [ERR_W-1:0]  res_err_o,
  output logic [RECV_W-1:0] res_recv_o
);

  localparam logic [15:0]       STABLE_TGT = 16'(ALIGN_STABLE);
  localparam logic [RECV_W-1:0] WIN_LEN    = RECV_W'(BURST_LEN);

  state_e            state_q, state_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [NB_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [RECV_W-1:0] base_q, base_d;
  logic [RECV_W-1:0] prev_q;
  logic [15:0]       stable_q, stable_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              aborted_q, aborted_d;
  logic [ERR_W-1:0]  res_err_q, res_err_d;
  logic [RECV_W-1:0] res_recv_q, res_recv_d;

  logic [RECV_W-1:0] delta;
  logic              progress, in_wait, wd_clr, wd_exp;

  // Modulo-2^58 distance so a base near the top of the counter still completes.
  assign delta    = recv_cnt_i - base_q;
  assign progress = (recv_cnt_i != prev_q);
  assign in_wait  = (state_q == ALIGN) || (state_q == BURST);
  assign wd_clr   = !in_wait || ((state_q == BURST) && progress);

  ber_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wd_clr),
    .en_i      (in_wait),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d     = state_q;
    nb_d        = nb_q;
    burst_cnt_d = burst_cnt_q;
    base_d      = base_q;
    stable_d    = stable_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    aborted_d   = aborted_q;
    res_err_d   = res_err_q;
    res_recv_d  = res_recv_q;

    case (state_q)
      IDLE: begin
        if (start_i && (nburst_i != '0)) begin
          state_d     = CLEAR;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          aborted_d   = 1'b0;
          burst_cnt_d = '0;
        end
      end
      CLEAR: begin
        nb_d     = nburst_i;
        stable_d = '0;
        if (abort_i) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else begin
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        stable_d = aligned_i ? stable_q + 1'b1 : '0;
        if (abort_i) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else if (stable_d == STABLE_TGT) begin
          state_d = ARM;
        end else if (wd_exp) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end
      end
      ARM: begin
        base_d = recv_cnt_i;
        if (abort_i) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (abort_i) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else if (delta == WIN_LEN) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          state_d     = (burst_cnt_d == nb_q) ? FINISH : ARM;
        end else if (wd_exp) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end
      end
      FINISH: begin
        res_err_d  = err_cnt_i;
        res_recv_d = recv_cnt_i;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      nb_q        <= '0;
      burst_cnt_q <= '0;
      base_q      <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
      res_err_q   <= '0;
      res_recv_q  <= '0;
    end else begin
      state_q     <= state_d;
      nb_q        <= nb_d;
      burst_cnt_q <= burst_cnt_d;
      base_q      <= base_d;
      prev_q      <= recv_cnt_i;
      stable_q    <= stable_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      aborted_q   <= aborted_d;
      res_err_q   <= res_err_d;
      res_recv_q  <= res_recv_d;
    end
  end

  assign clr_o       = (state_q == CLEAR);
  assign init_o      = (state_q == ARM);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign aborted_o   = aborted_q;
  assign burst_cnt_o = burst_cnt_q;
  assign res_err_o   = res_err_q;
  assign res_recv_o  = res_recv_q;

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Directed bench for ber_test_sequencer with a small receiver model (clears on CLR, counts one
// word per cycle within each armed 1024-word window).
module tb_ber_test_sequencer;

  localparam int AS = 16;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst, start, abort, aligned;
  logic [15:0] nburst;
  logic [57:0] recv_cnt;
  logic [63:0] err_cnt;
  logic        clr, init, busy, done, tmo, abrt;
  logic [15:0] bcnt;
  logic [63:0] res_err;
  logic [57:0] res_recv;

  ber_test_sequencer #(.ALIGN_STABLE(AS), .TIMEOUT_CYC(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .nburst_i    (nburst),
    .aligned_i   (aligned),
    .recv_cnt_i  (recv_cnt),
    .err_cnt_i   (err_cnt),
    .clr_o       (clr),
    .init_o      (init),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (tmo),
    .aborted_o   (abrt),
    .burst_cnt_o (bcnt),
    .res_err_o   (res_err),
    .res_recv_o  (res_recv)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  int          cyc = 0, t0 = 0;
  int          n_init = 0, first_init = 0, last_init = 0, init_gap = 0;
  logic        cnt_en = 1'b0, tog = 1'b0, abort_arm = 1'b0;
  logic [57:0] win_base = '0, win_end = '0, clr_val = '0;
  logic [57:0] stop_word = 58'd5000;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock; outputs are looked at 1 time unit after the edge, model inputs updated after that.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    abort = 1'b0;
    if (tog) aligned = cyc[3];
    if (cnt_en && recv_cnt != win_end && (recv_cnt - win_base) != stop_word)
      recv_cnt = recv_cnt + 58'd1;
    if (abort_arm && cnt_en && recv_cnt == win_end) begin
      abort     = 1'b1;
      abort_arm = 1'b0;
    end
    if (clr) begin
      recv_cnt = clr_val;
      cnt_en   = 1'b0;
    end
    if (init) begin
      n_init++;
      if (n_init == 1) first_init = cyc;
      else             init_gap   = cyc - last_init;
      last_init = cyc;
      win_base  = recv_cnt;
      win_end   = recv_cnt + 58'd1024;
      cnt_en    = 1'b1;
    end
  endtask

  task automatic go(input logic [15:0] nb);
    n_init = 0;
    nburst = nb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    t0     = cyc - 1;
  endtask

  task automatic run_done(input int budget, input string tag);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; aligned = 1'b1;
    nburst = '0; recv_cnt = '0; err_cnt = 64'd37;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clr",  64'(clr),  64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcnt", 64'(bcnt), 64'd0);
    rst = 1'b0;
    tick();

    // Two full windows with alignment steady
    go(16'd2);
    chk("t1_clr",  64'(clr),  64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_clr_off", 64'(clr), 64'd0);
    run_done(4000, "t1_done");
    chk("t1_init_lat", 64'(first_init - t0), 64'd18);
    chk("t1_init_gap", 64'(init_gap), 64'd1025);
    chk("t1_n_init",   64'(n_init), 64'd2);
    chk("t1_bcnt",     64'(bcnt), 64'd2);
    chk("t1_res_recv", 64'(res_recv), 64'd2048);
    chk("t1_res_err",  res_err, 64'd37);
    chk("t1_tmo",      64'(tmo), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // START with NBURST=0 must be ignored and leave DONE intact
    go(16'd0);
    chk("nb0_busy", 64'(busy), 64'd0);
    chk("nb0_done", 64'(done), 64'd1);

    // Alignment never stable long enough: timeout out of ALIGN
    tog = 1'b1;
    err_cnt = '1;
    go(16'd3);
    chk("t2_done_clr", 64'(done), 64'd0);
    run_done(500, "t2_done");
    chk("t2_done_cyc", 64'(cyc - t0), 64'd103);
    chk("t2_n_init",   64'(n_init), 64'd0);
    chk("t2_tmo",      64'(tmo), 64'd1);
    chk("t2_bcnt",     64'(bcnt), 64'd0);
    chk("t2_res_err",  res_err, 64'hFFFF_FFFF_FFFF_FFFF);
    tog = 1'b0;
    aligned = 1'b1;

    // Receiver stalls at word 500 of the first window
    stop_word = 58'd500;
    err_cnt = 64'd5;
    go(16'd2);
    run_done(3000, "t3_done");
    chk("t3_tmo",      64'(tmo), 64'd1);
    chk("t3_bcnt",     64'(bcnt), 64'd0);
    chk("t3_res_recv", 64'(res_recv), 64'd500);
    chk("t3_n_init",   64'(n_init), 64'd1);
    stop_word = 58'd5000;

    // Abort lands on the same cycle the first window completes
    abort_arm = 1'b1;
    go(16'd2);
    run_done(3000, "t4_done");
    chk("t4_abrt",     64'(abrt), 64'd1);
    chk("t4_tmo",      64'(tmo), 64'd0);
    chk("t4_bcnt",     64'(bcnt), 64'd0);
    chk("t4_res_recv", 64'(res_recv), 64'd1024);
    chk("t4_n_init",   64'(n_init), 64'd1);

    // Window straddles the 58-bit wrap
    clr_val = 58'd0 - 58'd512;
    go(16'd1);
    run_done(3000, "t5_done");
    chk("t5_bcnt",     64'(bcnt), 64'd1);
    chk("t5_res_recv", 64'(res_recv), 64'd512);
    chk("t5_tmo",      64'(tmo), 64'd0);
    chk("t5_abrt",     64'(abrt), 64'd0);

    // Reset in the middle of a window
    clr_val = '0;
    go(16'd1);
    for (int k = 0; k < 100 && n_init == 0; k++) tick();
    repeat (20) tick();
    chk("t6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("t6_busy",     64'(busy), 64'd0);
    chk("t6_clr",      64'(clr), 64'd0);
    chk("t6_init",     64'(init), 64'd0);
    chk("t6_done",     64'(done), 64'd0);
    chk("t6_tmo",      64'(tmo), 64'd0);
    chk("t6_abrt",     64'(abrt), 64'd0);
    chk("t6_bcnt",     64'(bcnt), 64'd0);
    chk("t6_res_err",  res_err, 64'd0);
    chk("t6_res_recv", 64'(res_recv), 64'd0);
    rst = 1'b0;
    tick();
    go(16'd0);
    chk("t6_nb0_busy", 64'(busy), 64'd0);
    tick();
    chk("t6_nb0_busy2", 64'(busy), 64'd0);
    chk("t6_nb0_clr",   64'(clr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
